// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit add/subtract, one 4-bit lookahead group resolved per pipeline stage
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam int GROUPS = WIDTH / 4;
  logic             adv;
  logic             v_r [GROUPS];
  logic [WIDTH-1:0] a_r [GROUPS];
  logic [WIDTH-1:0] b_r [GROUPS];
  logic [WIDTH-1:0] s_r [GROUPS];
  logic             c_r [GROUPS];
  logic [WIDTH-1:0] ns  [GROUPS];
  logic             co  [GROUPS];
  logic             cm  [GROUPS];
  logic [3:0]       gs  [GROUPS];
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic c1, c2, c3, c4;
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c0);
    return {c4, c3, p ^ {c3, c2, c1, c0}};
  endfunction
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  // resolve group k of the operation sitting in stage k and merge its sum bits
  always_comb begin
    for (int k = 0; k < GROUPS; k++) begin
      {co[k], cm[k], gs[k]} = cla4(a_r[k][4*k +: 4], b_r[k][4*k +: 4], c_r[k]);
      ns[k]                 = s_r[k];
      ns[k][4*k +: 4]       = gs[k];
    end
  end
  // whole pipeline advances together or holds together; the last stage produces result and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < GROUPS; k++) begin
        v_r[k] <= 1'b0;
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      v_r[0] <= in_valid;
      a_r[0] <= A;
      b_r[0] <= sub ? ~B : B;
      s_r[0] <= '0;
      c_r[0] <= sub | carryin;
      for (int k = 1; k < GROUPS; k++) begin
        v_r[k] <= v_r[k-1];
        a_r[k] <= a_r[k-1];
        b_r[k] <= b_r[k-1];
        s_r[k] <= ns[k-1];
        c_r[k] <= co[k-1];
      end
      out_valid <= v_r[GROUPS-1];
      sum       <= ns[GROUPS-1];
      carry     <= co[GROUPS-1];
      overflow  <= cm[GROUPS-1] ^ co[GROUPS-1];
      zero      <= ~|ns[GROUPS-1];
    end
  end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed and sweep checks of the pipelined adder against an arithmetic model
module tb_pipelined_cla_adder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [15:0] A = '0, B = '0, sum;
  logic        carryin = 1'b0, sub = 1'b0, carry, overflow, zero;
  logic        i4_v = 1'b0, i4_r, o4_v, c4i = 1'b0, sb4 = 1'b0, cy4, of4, z4;
  logic [3:0]  a4 = '0, b4 = '0, sum4;
  logic        i8_v = 1'b0, i8_r, o8_v, c8i = 1'b0, sb8 = 1'b0, cy8, of8, z8;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  int          n_cmp = 0, n_bad = 0, n_pop = 0, cyc = 0;
  logic [18:0] q16[$], q8[$], q4[$];
  int          t8[$], t4[$];
  logic [18:0] held;
  logic        held_v = 1'b0;

  pipelined_cla_adder #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .carryin(carryin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow), .zero(zero));
  pipelined_cla_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(i8_v), .in_ready(i8_r), .A(a8), .B(b8),
    .carryin(c8i), .sub(sb8), .out_valid(o8_v), .out_ready(1'b1),
    .sum(sum8), .carry(cy8), .overflow(of8), .zero(z8));
  pipelined_cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(i4_v), .in_ready(i4_r), .A(a4), .B(b4),
    .carryin(c4i), .sub(sb4), .out_valid(o4_v), .out_ready(1'b1),
    .sum(sum4), .carry(cy4), .overflow(of4), .zero(z4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // {zero, overflow, carry, sum} of a w-bit operation, from signed/unsigned integer arithmetic
  function automatic logic [18:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic s);
    int ua, ub, sa, sb, r, t, full, half;
    logic [15:0] sm;
    logic c, o;
    full = 1 << w;
    half = full / 2;
    ua = {16'b0, a} & (full - 1);
    ub = {16'b0, b} & (full - 1);
    sa = ua >= half ? ua - full : ua;
    sb = ub >= half ? ub - full : ub;
    if (s) begin
      t = ua - ub;
      c = ua >= ub;
      r = sa - sb;
    end else begin
      t = ua + ub + int'(ci);
      c = t >= full;
      r = sa + sb + int'(ci);
    end
    sm = 16'(t & (full - 1));
    o  = (r >= half) || (r < -half);
    return {sm == 16'h0, o, c, sm};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      q16.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) chk("hold", 32'({out_valid, zero, overflow, carry, sum}), 32'({1'b1, held}));
      held_v = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (q16.size() == 0) chk("spurious16", 32'(out_valid), 0);
          else begin
            chk("res16", 32'({zero, overflow, carry, sum}), 32'(q16.pop_front()));
            n_pop++;
          end
        end else begin
          chk("in_ready_stall", 32'(in_ready), 0);
          held   = {zero, overflow, carry, sum};
          held_v = 1'b1;
        end
      end
      if (in_valid && in_ready) q16.push_back(model(16, A, B, carryin, sub));
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      q8.delete(); t8.delete(); q4.delete(); t4.delete();
    end else begin
      if (o8_v) begin
        if (q8.size() == 0) chk("spurious8", 32'(o8_v), 0);
        else begin
          chk("res8", 32'({z8, of8, cy8, 8'b0, sum8}), 32'(q8.pop_front()));
          chk("lat8", 32'(cyc - t8.pop_front()), 2);
        end
      end
      if (o4_v) begin
        if (q4.size() == 0) chk("spurious4", 32'(o4_v), 0);
        else begin
          chk("res4", 32'({z4, of4, cy4, 12'b0, sum4}), 32'(q4.pop_front()));
          chk("lat4", 32'(cyc - t4.pop_front()), 1);
        end
      end
      if (i8_v && i8_r) begin
        q8.push_back(model(8, {8'b0, a8}, {8'b0, b8}, c8i, sb8));
        t8.push_back(cyc + 1);
      end
      if (i4_v && i4_r) begin
        q4.push_back(model(4, {12'b0, a4}, {12'b0, b4}, c4i, sb4));
        t4.push_back(cyc + 1);
      end
    end
  end

  task automatic run1(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s,
                      input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    int n;
    in_valid = 1'b1; A = a; B = b; carryin = ci; sub = s;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; carryin = ~ci; sub = ~s;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 20);
    chk("latency", 32'(n), 4);
    chk("sum", 32'(sum), 32'(es));
    chk("carry", 32'(carry), 32'(ec));
    chk("overflow", 32'(overflow), 32'(eo));
    chk("zero", 32'(zero), 32'(ez));
    @(posedge clk); #1;
    chk("pulse", 32'(out_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i, guard, p0;
    logic hs, bad;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_flags", 32'({sum, carry, overflow, zero}), 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    run1(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run1(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run1(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run1(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run1(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
    run1(16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run1(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    p0 = n_pop; i = 0; guard = 0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        while (i < 8 && guard < 50) begin
          in_valid = 1'b1; A = 16'(i); B = 16'(16'h1111 * i); sub = i[0]; carryin = 1'b0;
          @(negedge clk);
          hs = in_ready;
          @(posedge clk); #1;
          if (hs) i++;
          guard++;
        end
        in_valid = 1'b0;
      end
    join
    guard = 0;
    while (q16.size() != 0 && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("stream_count", 32'(n_pop - p0), 8);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; A = 16'(16'h0101 * (k + 1)); B = 16'h0010; sub = 1'b0; carryin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_sum", 32'(sum), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      bad |= out_valid;
    end
    chk("flush_no_valid", 32'(bad), 0);
    run1(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    fork
      begin
        for (int x = 0; x < 1024; x++) begin
          i4_v = 1'b1; a4 = 4'(x); b4 = 4'(x >> 4); c4i = x[8]; sb4 = x[9];
          @(posedge clk); #1;
        end
        i4_v = 1'b0;
      end
      begin
        for (int x = 0; x < 400; x++) begin
          i8_v = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); c8i = 1'($urandom); sb8 = 1'($urandom);
          @(posedge clk); #1;
        end
        i8_v = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("drain8", 32'(q8.size()), 0);
    chk("drain4", 32'(q4.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
